sprite_animator: RTL and testbench

- Parametrised successor to the single-character ending sprite. One instance renders one animated, scaled character sprite from a shared sprite-sheet frame RAM.
- Appears when the level scroll position passes a trigger, then cycles N animation frames.
- Sits between the VGA DrawX/DrawY scan path and the colour mapper. Outputs a pipelined RGB pixel plus a hit flag.
- Animation timing uses a synchronous tick enable on Clk (no derived clocks).

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_animator_anim_tick_gen.sv | 21 ++
 rtl/sprite_animator.sv | 128 ++++++++++++
 tb/tb_sprite_animator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite state, colour type and character palette
package sprite_pkg;

    typedef enum logic [1:0] {HIDDEN, READY, ANIM, DONE} sprite_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int TRANSPARENT_IDX = 0;

    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hFFFDFB, 24'hB53121, 24'hF83800,
        24'hE18300, 24'h1D7B01, 24'hAC7C00, 24'hD4E7C7,
        24'h057987, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/sprite_animator_anim_tick_gen.sv
// anim_tick_gen: one-cycle animation tick every TICK_DIV clocks, no derived clock
module anim_tick_gen #(
    parameter int TICK_DIV = 3_000_000
) (
    input  logic Clk,
    input  logic Reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(TICK_DIV - 1);

    // free-running divider, wraps on the tick cycle
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + W'(1);

endmodule

// File: rtl/sprite_animator.sv
// sprite_animator: scaled animated sprite over the VGA scan; SPRITE_HFLIP_EN adds hflip mirror input
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int X_HOME       = 350,
    parameter int Y_HOME       = 352,
    parameter int SRC_W        = 13,
    parameter int SRC_H        = 24,
    parameter int SCALE_LOG2   = 1,
    parameter int SHEET_W      = 188,
    parameter int SHEET_X0     = 43,
    parameter int SHEET_Y0     = 114,
    parameter int N_FRAMES     = 2,
    parameter int TRIGGER_STEP = 400,
    parameter int TICK_DIV     = 3_000_000,
    parameter int ONE_SHOT     = 0,
    parameter int RAM_LAT      = 1,
    parameter int ADDR_W       = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [8:0]        scroll_pos,
    input  logic              freeze,
`ifdef SPRITE_HFLIP_EN
    input  logic              hflip,
`endif
    output logic [ADDR_W-1:0] read_addr,
    input  logic [3:0]        ram_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              is_sprite,
    output logic [2:0]        anim_frame,
    output logic              visible
);

    localparam logic [2:0] LAST = 3'(N_FRAMES - 1);

    sprite_state_t state_q, state_d;
    logic [2:0]    frame_d;
    logic          tick;
    logic          hit;
    logic [10:0]   dx, dy, col, row;
    logic [19:0]   addr;
    logic [RAM_LAT:0] hit_sr;
    logic          opaque;

    anim_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (tick)
    );

    assign visible = state_q != HIDDEN;

    // animation state register
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state_q    <= HIDDEN;
            anim_frame <= '0;
        end else begin
            state_q    <= state_d;
            anim_frame <= frame_d;
        end

    // appearance and frame sequencing, advanced only on tick
    always_comb begin
        state_d = state_q;
        frame_d = anim_frame;
        if (tick)
            case (state_q)
                HIDDEN: if (scroll_pos > 9'(TRIGGER_STEP)) state_d = READY;
                READY: begin
                    state_d = ANIM;
                    frame_d = '0;
                end
                ANIM: if (!freeze) begin
                    if (anim_frame != LAST)  frame_d = anim_frame + 3'd1;
                    else if (ONE_SHOT != 0)  state_d = DONE;
                    else                     frame_d = '0;
                end
                default: ;
            endcase
    end

    assign dx  = {1'b0, DrawX} - 11'(X_HOME);
    assign dy  = {1'b0, DrawY} - 11'(Y_HOME);
    assign hit = visible && DrawX >= 10'(X_HOME) && DrawY >= 10'(Y_HOME)
              && dx < 11'(SRC_W << SCALE_LOG2) && dy < 11'(SRC_H << SCALE_LOG2);
`ifdef SPRITE_HFLIP_EN
    assign col = hflip ? 11'(SRC_W - 1) - (dx >> SCALE_LOG2) : dx >> SCALE_LOG2;
`else
    assign col = dx >> SCALE_LOG2;
`endif
    assign row  = dy >> SCALE_LOG2;
    assign addr = 20'(SHEET_X0) + 20'(anim_frame) * 20'(SRC_W) + 20'(col)
                + (20'(SHEET_Y0) + 20'(row)) * 20'(SHEET_W);

    // address stage plus hit delay line aligned with RAM read data
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            read_addr <= '0;
            hit_sr    <= '0;
        end else begin
            read_addr <= hit ? ADDR_W'(addr) : '0;
            hit_sr[0] <= hit;
            for (int i = 1; i <= RAM_LAT; i++) hit_sr[i] <= hit_sr[i-1];
        end

    assign opaque = hit_sr[RAM_LAT] && ram_data != 4'(TRANSPARENT_IDX) && ram_data <= 4'd9;

    // palette output stage; transparent and unused indices give no pixel
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            is_sprite <= 1'b0;
        end else begin
            Red       <= opaque ? PALETTE[ram_data].r : 8'd0;
            Green     <= opaque ? PALETTE[ram_data].g : 8'd0;
            Blue      <= opaque ? PALETTE[ram_data].b : 8'd0;
            is_sprite <= opaque;
        end

endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: randomized scoreboard bench for sprite_animator (looping and one-shot instances)
module tb_sprite_animator;

    localparam int TD = 4;

    logic        Clk = 0, Reset = 1;
    logic [9:0]  DrawX = 0, DrawY = 0;
    logic [8:0]  scroll_pos = 0;
    logic        freeze = 0;
    logic [3:0]  ram_data = 0;
    logic [18:0] read_addr, read_addr_b;
    logic [7:0]  Red, Green, Blue, red_b, green_b, blue_b;
    logic        is_sprite, is_sprite_b, visible, visible_b;
    logic [2:0]  anim_frame, anim_frame_b;
`ifdef SPRITE_HFLIP_EN
    logic        hflip = 0;
`endif

    int n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct {int due; int val;} addr_exp_t;
    typedef struct {int due; int spr; int rgb; int chk_rgb;} px_exp_t;
    addr_exp_t aq[$];
    px_exp_t   pq[$];

    int pal [16] = '{0, 'hFFFDFB, 'hB53121, 'hF83800, 'hE18300, 'h1D7B01, 'hAC7C00,
                     'hD4E7C7, 'h057987, 'h000000, 0, 0, 0, 0, 0, 0};

    int m_cnt = 0;
    int m_st [2];
    int m_fr [2];
    int nf [2] = '{2, 3};
    int os [2] = '{0, 1};

    sprite_animator #(.TICK_DIV(TD)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .scroll_pos(scroll_pos), .freeze(freeze),
`ifdef SPRITE_HFLIP_EN
        .hflip(hflip),
`endif
        .read_addr(read_addr), .ram_data(ram_data), .Red(Red), .Green(Green), .Blue(Blue),
        .is_sprite(is_sprite), .anim_frame(anim_frame), .visible(visible)
    );

    sprite_animator #(.TICK_DIV(TD), .N_FRAMES(3), .ONE_SHOT(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .scroll_pos(scroll_pos), .freeze(freeze),
`ifdef SPRITE_HFLIP_EN
        .hflip(hflip),
`endif
        .read_addr(read_addr_b), .ram_data(4'd0), .Red(red_b), .Green(green_b), .Blue(blue_b),
        .is_sprite(is_sprite_b), .anim_frame(anim_frame_b), .visible(visible_b)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] mem(input int a);
        if (a == 21865) return 4'd3;
        if (a % 188 == 45) return 4'd0;
        return 4'(((a * 37) ^ (a >> 5)) & 15);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) ram_data <= mem(int'(read_addr));

    // reference: tick every TD cycles; appear above 400, then step frames
    always @(posedge Clk or posedge Reset)
        if (Reset) begin
            m_cnt <= 0;
            for (int i = 0; i < 2; i++) begin
                m_st[i] <= 0;
                m_fr[i] <= 0;
            end
        end else begin
            m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
            if (m_cnt == TD - 1)
                for (int i = 0; i < 2; i++)
                    if (m_st[i] == 0 && scroll_pos > 400) m_st[i] <= 1;
                    else if (m_st[i] == 1) begin
                        m_st[i] <= 2;
                        m_fr[i] <= 0;
                    end else if (m_st[i] == 2 && !freeze) begin
                        if (m_fr[i] < nf[i] - 1) m_fr[i] <= m_fr[i] + 1;
                        else if (os[i] != 0)     m_st[i] <= 3;
                        else                     m_fr[i] <= 0;
                    end
        end

    // monitor: state every cycle, pixel pipeline when each entry falls due
    always @(negedge Clk) begin
        addr_exp_t e;
        px_exp_t   p;
        chk("visible", int'(visible), int'(m_st[0] != 0));
        chk("anim_frame", int'(anim_frame), m_fr[0]);
        chk("visible_b", int'(visible_b), int'(m_st[1] != 0));
        chk("anim_frame_b", int'(anim_frame_b), m_fr[1]);
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            e = aq.pop_front();
            chk("addr_due", e.due, cyc);
            chk("read_addr", int'(read_addr), e.val);
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            chk("px_due", p.due, cyc);
            chk("is_sprite", int'(is_sprite), p.spr);
            if (p.chk_rgb != 0) chk("rgb", int'({Red, Green, Blue}), p.rgb);
        end
    end

    task automatic drive_px(input int x, input int y);
        int hit, a, idx;
        px_exp_t p;
        DrawX = 10'(x);
        DrawY = 10'(y);
        hit = int'(m_st[0] != 0 && x >= 350 && y >= 352 && x < 350 + 26 && y < 352 + 48);
        a = (hit != 0) ? (43 + m_fr[0] * 13 + (x - 350) / 2 + (114 + (y - 352) / 2) * 188) % (1 << 19) : 0;
        aq.push_back('{cyc + 1, a});
        idx = int'(mem(a));
        p.due = cyc + 3;
        p.spr = int'(hit != 0 && idx >= 1 && idx <= 9);
        p.rgb = (p.spr != 0) ? pal[idx] : 0;
        p.chk_rgb = int'(hit == 0 || idx <= 9);
        pq.push_back(p);
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_px(input int n);
        for (int i = 0; i < n; i++) drive_px(int'($urandom_range(340, 390)), int'($urandom_range(345, 405)));
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_addr"}, int'(read_addr), 0);
        chk({nm, "_rgb"}, int'({Red, Green, Blue}), 0);
        chk({nm, "_is_sprite"}, int'(is_sprite), 0);
        chk({nm, "_visible"}, int'(visible), 0);
        chk({nm, "_frame"}, int'(anim_frame), 0);
        chk({nm, "_visible_b"}, int'(visible_b), 0);
    endtask

    initial begin
        int f;
        repeat (3) @(posedge Clk);
        #1;
        check_cleared("reset");
        Reset = 0;
        scroll_pos = 9'd400;
        rand_px(20);
        chk("hidden_at_400", int'(visible), 0);
        scroll_pos = 9'd401;
        rand_px(40);
        for (int i = 0; i < 20 && !(m_st[0] == 2 && m_fr[0] == 1); i++) rand_px(1);
        chk("reach_frame1", m_fr[0], 1);
        drive_px(353, 357);
        chk("addr_21865", int'(read_addr), 21865);
        drive_px(375, 360);
        drive_px(376, 360);
        chk("rgb_F83800", int'({Red, Green, Blue}), 'hF83800);
        chk("is_sprite_idx3", int'(is_sprite), 1);
        drive_px(349, 360);
        for (int i = 0; i < 20 && m_fr[0] != 0; i++) rand_px(1);
        drive_px(354, 360);
        rand_px(4);
        freeze = 1;
        f = int'(anim_frame);
        rand_px(5 * TD);
        chk("freeze_hold", int'(anim_frame), f);
        freeze = 0;
        rand_px(3 * TD);
        scroll_pos = 9'd0;
        rand_px(12 * TD);
        chk("oneshot_last", int'(anim_frame_b), 2);
        chk("oneshot_visible", int'(visible_b), 1);
        for (int i = 0; i < TD && m_cnt != 1; i++) rand_px(1);
        #2;
        Reset = 1;
        #1;
        check_cleared("midreset");
        aq.delete();
        pq.delete();
        @(posedge Clk);
        #1;
        Reset = 0;
        scroll_pos = 9'd400;
        rand_px(12);
        chk("rehidden_at_400", int'(visible), 0);
        scroll_pos = 9'd401;
        rand_px(60);
        repeat (5) @(posedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
